// File: rtl/ts_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : ts_deframer
//  Purpose  : Serial MPEG-TS deframer. Samples ts_sync/ts_valid/ts_d0 on
//             spi_clk, assembles MSB-first bytes, hunts for and locks onto
//             the PKT_LEN-byte packet grid using SYNC_BYTE, and delivers the
//             locked byte stream with packet markers and status.
//  Ports    : spi_clk    - clock, all state changes on the rising edge
//             reset      - asynchronous, active-low reset
//             ts_sync    - byte-alignment marker (qualified by ts_valid)
//             ts_valid   - serial bit valid
//             ts_d0      - serial data, MSB first
//             byte_data  - assembled byte (meaningful with byte_valid)
//             byte_valid - one-cycle pulse per delivered byte
//             pkt_start  - with byte_valid on packet index 0
//             pkt_end    - with byte_valid on packet index PKT_LEN-1
//             sync_lock  - high while LOCKED
//             sync_miss  - pulse on a sync mismatch while LOCKED
//             frag_err   - pulse when a partial byte is discarded
//             pkt_cnt    - packets completed while LOCKED (wraps)
//             err_cnt    - sync_miss + frag_err events (saturates at 0xFF)
//  Revision : 1.0 - initial release
// ============================================================================
module ts_deframer #(
   parameter int         PKT_LEN    = 188,
   parameter logic [7:0] SYNC_BYTE  = 8'h47,
   parameter int         LOCK_CNT   = 3,
   parameter int         UNLOCK_CNT = 3
) (
   input  logic        spi_clk,
   input  logic        reset,
   input  logic        ts_sync,
   input  logic        ts_valid,
   input  logic        ts_d0,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   output logic        pkt_start,
   output logic        pkt_end,
   output logic        sync_lock,
   output logic        sync_miss,
   output logic        frag_err,
   output logic [15:0] pkt_cnt,
   output logic [7:0]  err_cnt
);

   localparam logic [7:0] c_last_idx   = 8'(PKT_LEN - 1);
   localparam logic [7:0] c_lock_cnt   = 8'(LOCK_CNT);
   localparam logic [7:0] c_unlock_cnt = 8'(UNLOCK_CNT);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Only the seven most recent bits need storing: the eighth comes
   // straight from ts_d0 on the edge that completes the byte.
   logic [6:0]  sh_d,         sh_q;
   logic [2:0]  bit_cnt_d,    bit_cnt_q;
   state_t      state_d,      state_q;
   logic [7:0]  idx_d,        idx_q;
   logic [7:0]  good_d,       good_q;
   logic [7:0]  miss_d,       miss_q;
   logic [7:0]  byte_data_d,  byte_data_q;
   logic        byte_valid_d, byte_valid_q;
   logic        pkt_start_d,  pkt_start_q;
   logic        pkt_end_d,    pkt_end_q;
   logic        sync_lock_d,  sync_lock_q;
   logic        sync_miss_d,  sync_miss_q;
   logic        frag_err_d,   frag_err_q;
   logic [15:0] pkt_cnt_d,    pkt_cnt_q;
   logic [7:0]  err_cnt_d,    err_cnt_q;

   logic [7:0]  new_byte;
   logic        byte_done;
   logic        frag_det;
   logic        out_en;
   logic        is_sync;
   logic [7:0]  idx_next;
   logic [8:0]  err_sum;

   // ------------------------------------------------------------------
   // Bit assembly and byte alignment
   // ------------------------------------------------------------------
   always_comb begin
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      byte_done = 1'b0;
      frag_det  = 1'b0;
      new_byte  = {sh_q, ts_d0};
      if (ts_valid) begin
         sh_d = new_byte[6:0];
         if (ts_sync) begin
            // The marked bit is the MSB of a fresh byte; anything already
            // collected belongs to a broken byte and is dropped.
            frag_det  = (bit_cnt_q != 3'd0);
            bit_cnt_d = 3'd1;
         end else if (bit_cnt_q == 3'd7) begin
            byte_done = 1'b1;
            bit_cnt_d = 3'd0;
         end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
      end else if (bit_cnt_q != 3'd0) begin
         // Clearing the counter makes this fire only once per gap.
         frag_det  = 1'b1;
         bit_cnt_d = 3'd0;
      end
   end

   // ------------------------------------------------------------------
   // Packet-grid state machine
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      good_d      = good_q;
      miss_d      = miss_q;
      out_en      = 1'b0;
      sync_miss_d = 1'b0;
      is_sync     = (new_byte == SYNC_BYTE);
      idx_next    = (idx_q == c_last_idx) ? 8'd0 : idx_q + 8'd1;

      if (byte_done) begin
         case (state_q)
            ST_HUNT: begin
               if (is_sync) begin
                  state_d = ST_VERIFY;
                  idx_d   = 8'd1;
                  good_d  = 8'd1;
               end
            end

            ST_VERIFY: begin
               idx_d = idx_next;
               if (idx_q == 8'd0) begin
                  if (is_sync) begin
                     good_d = good_q + 8'd1;
                     if ((good_q + 8'd1) >= c_lock_cnt) begin
                        // The confirming sync byte is the first one delivered.
                        state_d = ST_LOCKED;
                        miss_d  = 8'd0;
                        out_en  = 1'b1;
                     end
                  end else begin
                     state_d = ST_HUNT;
                     idx_d   = 8'd0;
                     good_d  = 8'd0;
                  end
               end
            end

            ST_LOCKED: begin
               idx_d  = idx_next;
               out_en = 1'b1;
               if (idx_q == 8'd0) begin
                  if (is_sync) begin
                     miss_d = 8'd0;
                  end else begin
                     sync_miss_d = 1'b1;
                     miss_d      = miss_q + 8'd1;
                     if ((miss_q + 8'd1) >= c_unlock_cnt) begin
                        // Lock is lost on this byte, so it is not delivered.
                        state_d = ST_HUNT;
                        idx_d   = 8'd0;
                        good_d  = 8'd0;
                        miss_d  = 8'd0;
                        out_en  = 1'b0;
                     end
                  end
               end
            end

            default: begin
               state_d = ST_HUNT;
               idx_d   = 8'd0;
               good_d  = 8'd0;
               miss_d  = 8'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registered outputs and status counters
   // ------------------------------------------------------------------
   always_comb begin
      byte_valid_d = out_en;
      pkt_start_d  = out_en && (idx_q == 8'd0);
      pkt_end_d    = out_en && (idx_q == c_last_idx);
      byte_data_d  = out_en ? new_byte : byte_data_q;
      sync_lock_d  = (state_d == ST_LOCKED);
      frag_err_d   = frag_det;
      pkt_cnt_d    = pkt_cnt_q + {15'd0, pkt_end_d};
      err_sum      = {1'b0, err_cnt_q} + {8'd0, sync_miss_d} + {8'd0, frag_err_d};
      err_cnt_d    = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   always_ff @(posedge spi_clk or negedge reset) begin
      if (!reset) begin
         sh_q         <= 7'd0;
         bit_cnt_q    <= 3'd0;
         state_q      <= ST_HUNT;
         idx_q        <= 8'd0;
         good_q       <= 8'd0;
         miss_q       <= 8'd0;
         byte_data_q  <= 8'd0;
         byte_valid_q <= 1'b0;
         pkt_start_q  <= 1'b0;
         pkt_end_q    <= 1'b0;
         sync_lock_q  <= 1'b0;
         sync_miss_q  <= 1'b0;
         frag_err_q   <= 1'b0;
         pkt_cnt_q    <= 16'd0;
         err_cnt_q    <= 8'd0;
      end else begin
         sh_q         <= sh_d;
         bit_cnt_q    <= bit_cnt_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         good_q       <= good_d;
         miss_q       <= miss_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         pkt_start_q  <= pkt_start_d;
         pkt_end_q    <= pkt_end_d;
         sync_lock_q  <= sync_lock_d;
         sync_miss_q  <= sync_miss_d;
         frag_err_q   <= frag_err_d;
         pkt_cnt_q    <= pkt_cnt_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign byte_data  = byte_data_q;
   assign byte_valid = byte_valid_q;
   assign pkt_start  = pkt_start_q;
   assign pkt_end    = pkt_end_q;
   assign sync_lock  = sync_lock_q;
   assign sync_miss  = sync_miss_q;
   assign frag_err   = frag_err_q;
   assign pkt_cnt    = pkt_cnt_q;
   assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ts_deframer
//  Purpose  : Self-checking bench for ts_deframer. A table of whole packets
//             drives lock acquisition and sync loss; hand-written sequences
//             cover fragments, realignment, async reset and err_cnt
//             saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ts_deframer;

   logic        spi_clk = 1'b0;
   logic        reset;
   logic        ts_sync;
   logic        ts_valid;
   logic        ts_d0;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        pkt_start;
   logic        pkt_end;
   logic        sync_lock;
   logic        sync_miss;
   logic        frag_err;
   logic [15:0] pkt_cnt;
   logic [7:0]  err_cnt;

   int total = 0;
   int bad   = 0;

   // Pulse monitors sampled on the falling edge, away from the active edge.
   int         bv_cnt        = 0;
   int         end_cnt       = 0;
   int         frag_cnt      = 0;
   logic [7:0] last_end_data = 8'd0;

   always #5 spi_clk = ~spi_clk;

   ts_deframer #(
      .PKT_LEN    (188),
      .SYNC_BYTE  (8'h47),
      .LOCK_CNT   (3),
      .UNLOCK_CNT (3)
   ) dut (
      .spi_clk    (spi_clk),
      .reset      (reset),
      .ts_sync    (ts_sync),
      .ts_valid   (ts_valid),
      .ts_d0      (ts_d0),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .pkt_start  (pkt_start),
      .pkt_end    (pkt_end),
      .sync_lock  (sync_lock),
      .sync_miss  (sync_miss),
      .frag_err   (frag_err),
      .pkt_cnt    (pkt_cnt),
      .err_cnt    (err_cnt)
   );

   always @(negedge spi_clk) begin
      if (byte_valid) bv_cnt <= bv_cnt + 1;
      if (frag_err)   frag_cnt <= frag_cnt + 1;
      if (pkt_end) begin
         end_cnt       <= end_cnt + 1;
         last_end_data <= byte_data;
      end
   end

   typedef struct {
      logic [7:0]  sync_val;
      logic        exp_bv;
      logic        exp_start;
      logic        exp_lock;
      logic        exp_miss;
      logic [7:0]  exp_err;
      int          exp_pulses;
      int          exp_ends;
      logic [15:0] exp_pkts;
   } pkt_vec_t;

   pkt_vec_t vec [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge spi_clk);
      #1;
   endtask

   task automatic put_bit(input logic v, input logic s, input logic d);
      ts_valid = v;
      ts_sync  = s;
      ts_d0    = d;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_sync);
      for (int i = 7; i >= 0; i--) put_bit(1'b1, with_sync && (i == 7), b[i]);
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
   endtask

   task automatic send_payload();
      for (int b = 0; b < 187; b++) send_byte(8'(b), 1'b0);
   endtask

   task automatic idle();
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
      reset    = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic check_zero(input string tag);
      check({tag, " byte_data"},  32'(byte_data),  32'd0);
      check({tag, " byte_valid"}, 32'(byte_valid), 32'd0);
      check({tag, " pkt_start"},  32'(pkt_start),  32'd0);
      check({tag, " pkt_end"},    32'(pkt_end),    32'd0);
      check({tag, " sync_lock"},  32'(sync_lock),  32'd0);
      check({tag, " sync_miss"},  32'(sync_miss),  32'd0);
      check({tag, " frag_err"},   32'(frag_err),   32'd0);
      check({tag, " pkt_cnt"},    32'(pkt_cnt),    32'd0);
      check({tag, " err_cnt"},    32'(err_cnt),    32'd0);
   endtask

   initial begin
      int bv0;
      int end0;
      int fr0;

      //          sync   bv start lock miss err pulses ends pkts
      vec[0] = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   0, 0, 16'd0};
      vec[1] = '{8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   0, 0, 16'd0};
      vec[2] = '{8'h47, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 188, 1, 16'd1};
      vec[3] = '{8'h46, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 188, 1, 16'd2};
      vec[4] = '{8'h47, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 188, 1, 16'd3};
      vec[5] = '{8'h46, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 188, 1, 16'd4};
      vec[6] = '{8'h46, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 188, 1, 16'd5};
      vec[7] = '{8'h46, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4,   0, 0, 16'd5};

      reset    = 1'b0;
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
      ts_d0    = 1'b0;
      tick();
      tick();
      check_zero("reset");
      reset = 1'b1;
      tick();

      // ---- Table: whole packets through lock acquisition and sync loss ----
      for (int v = 0; v < 8; v++) begin
         bv0  = bv_cnt;
         end0 = end_cnt;
         send_byte(vec[v].sync_val, 1'b1);
         check($sformatf("pkt%0d byte_valid", v), 32'(byte_valid), 32'(vec[v].exp_bv));
         check($sformatf("pkt%0d pkt_start", v),  32'(pkt_start),  32'(vec[v].exp_start));
         check($sformatf("pkt%0d sync_lock", v),  32'(sync_lock),  32'(vec[v].exp_lock));
         check($sformatf("pkt%0d sync_miss", v),  32'(sync_miss),  32'(vec[v].exp_miss));
         check($sformatf("pkt%0d err_cnt", v),    32'(err_cnt),    32'(vec[v].exp_err));
         if (vec[v].exp_bv)
            check($sformatf("pkt%0d byte_data", v), 32'(byte_data), 32'(vec[v].sync_val));
         send_payload();
         idle();
         check($sformatf("pkt%0d pulses", v),  32'(bv_cnt - bv0),   32'(vec[v].exp_pulses));
         check($sformatf("pkt%0d ends", v),    32'(end_cnt - end0), 32'(vec[v].exp_ends));
         check($sformatf("pkt%0d pkt_cnt", v), 32'(pkt_cnt),        32'(vec[v].exp_pkts));
         if (vec[v].exp_ends > 0)
            check($sformatf("pkt%0d end_data", v), 32'(last_end_data), 32'h0000_00BA);
      end

      // ---- Fragmented byte and mid-byte realignment while LOCKED ----
      do_reset();
      for (int p = 0; p < 3; p++) begin
         send_byte(8'h47, 1'b1);
         send_payload();
      end
      idle();
      check("relock sync_lock", 32'(sync_lock), 32'd1);
      check("relock pkt_cnt",   32'(pkt_cnt),   32'd1);

      send_byte(8'h47, 1'b1);
      check("relock start", 32'(pkt_start), 32'd1);
      send_byte(8'h00, 1'b0);
      for (int i = 0; i < 5; i++) put_bit(1'b1, 1'b0, 1'b1);
      put_bit(1'b0, 1'b0, 1'b0);
      check("drop frag_err",   32'(frag_err),   32'd1);
      check("drop err_cnt",    32'(err_cnt),    32'd1);
      check("drop byte_valid", 32'(byte_valid), 32'd0);
      put_bit(1'b0, 1'b0, 1'b0);
      check("drop frag_once", 32'(frag_err), 32'd0);
      send_byte(8'hA5, 1'b1);
      check("a5 byte_valid", 32'(byte_valid), 32'd1);
      check("a5 byte_data",  32'(byte_data),  32'h0000_00A5);
      check("a5 pkt_start",  32'(pkt_start),  32'd0);
      check("a5 frag_err",   32'(frag_err),   32'd0);
      check("a5 sync_lock",  32'(sync_lock),  32'd1);

      // Three junk bits, then 0x3C whose MSB carries ts_sync.
      put_bit(1'b1, 1'b0, 1'b1);
      put_bit(1'b1, 1'b0, 1'b0);
      put_bit(1'b1, 1'b0, 1'b1);
      put_bit(1'b1, 1'b1, 1'b0);
      check("realign frag_err", 32'(frag_err), 32'd1);
      check("realign err_cnt",  32'(err_cnt),  32'd2);
      for (int i = 6; i >= 0; i--) put_bit(1'b1, 1'b0, 1'(8'h3C >> i));
      ts_valid = 1'b0;
      check("realign byte_valid", 32'(byte_valid), 32'd1);
      check("realign byte_data",  32'(byte_data),  32'h0000_003C);

      // ---- Asynchronous reset in the 5th bit of a byte ----
      for (int i = 7; i >= 4; i--) put_bit(1'b1, 1'b0, 1'(8'h55 >> i));
      ts_valid = 1'b1;
      ts_d0    = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_zero("async_reset");
      ts_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();

      // First valid bit after release is the MSB: 0x47 without ts_sync.
      bv0 = bv_cnt;
      send_byte(8'h47, 1'b0);
      check("post_reset byte_valid", 32'(byte_valid), 32'd0);
      send_payload();
      idle();
      send_byte(8'h47, 1'b1);
      check("post_reset p2 lock", 32'(sync_lock), 32'd0);
      send_payload();
      idle();
      check("post_reset no_output", 32'(bv_cnt - bv0), 32'd0);
      send_byte(8'h47, 1'b1);
      check("post_reset p3 lock",  32'(sync_lock),  32'd1);
      check("post_reset p3 bv",    32'(byte_valid), 32'd1);
      check("post_reset p3 data",  32'(byte_data),  32'h0000_0047);
      check("post_reset p3 start", 32'(pkt_start),  32'd1);

      // ---- err_cnt saturation with 300 fragment errors ----
      fr0 = frag_cnt;
      for (int e = 1; e <= 300; e++) begin
         put_bit(1'b1, 1'b0, 1'b1);
         put_bit(1'b0, 1'b0, 1'b0);
         if (e == 200) check("err_cnt at 200", 32'(err_cnt), 32'd200);
         if (e == 255) check("err_cnt at 255", 32'(err_cnt), 32'h0000_00FF);
      end
      idle();
      check("err_cnt saturated", 32'(err_cnt),         32'h0000_00FF);
      check("frag pulses",       32'(frag_cnt - fr0),  32'd300);
      check("sat lock kept",     32'(sync_lock),       32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
